// File: rtl/gray_pkg.sv
// Shared types and Gray-code helpers for the Gray count receiver.
// The optional error counter is enabled with the GRAY_RX_ERR_CNT_EN macro.
package gray_pkg;

    // Helpers work on a fixed wide vector; callers size-cast in and out.
    localparam int GRAY_MAX_W = 32;
    // Fewest synchronizer stages that give a usable MTBF.
    localparam int SYNC_MIN   = 2;

    typedef enum logic [1:0] {
        IDLE,
        TRACK,
        HOLD
    } gray_rx_state_t;

    // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
    function automatic logic [GRAY_MAX_W-1:0] g2b(input logic [GRAY_MAX_W-1:0] g);
        logic [GRAY_MAX_W-1:0] b;
        b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
        for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic logic [GRAY_MAX_W-1:0] b2g(input logic [GRAY_MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [5:0] popcount(input logic [GRAY_MAX_W-1:0] v);
        logic [5:0] c;
        c = '0;
        for (int i = 0; i < GRAY_MAX_W; i++) begin
            c = c + 6'(v[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/gray_count_receiver_if.sv
// Bus bundle between a Gray count source (master) and the receiver (slave).
// err_cnt exists only when GRAY_RX_ERR_CNT_EN is defined.
interface gray_count_receiver_if #(
    parameter int WIDTH = 4,
    parameter int POS_W = 16
);
    logic             en;
    logic [WIDTH-1:0] gray_in;
    logic [WIDTH-1:0] bin_out;
    logic             bin_valid;
    logic             step_up;
    logic             step_dn;
    logic             step_err;
    logic [POS_W-1:0] pos;
`ifdef GRAY_RX_ERR_CNT_EN
    logic [7:0]       err_cnt;

    modport master (output en, gray_in,
                    input  bin_out, bin_valid, step_up, step_dn, step_err, pos, err_cnt);
    modport slave  (input  en, gray_in,
                    output bin_out, bin_valid, step_up, step_dn, step_err, pos, err_cnt);
`else
    modport master (output en, gray_in,
                    input  bin_out, bin_valid, step_up, step_dn, step_err, pos);
    modport slave  (input  en, gray_in,
                    output bin_out, bin_valid, step_up, step_dn, step_err, pos);
`endif
endinterface

// File: rtl/gray_sync.sv
// Plain multi-flop synchronizer for a Gray bus; no logic between stages.
module gray_sync #(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] chain_reg [SYNC_STAGES];

    generate
        for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_stage
            if (gi == 0) begin : g_first
                // First stage captures the asynchronous bus.
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) chain_reg[gi] <= '0;
                    else     chain_reg[gi] <= d;
                end
            end else begin : g_next
                // Later stages let metastability resolve.
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) chain_reg[gi] <= '0;
                    else     chain_reg[gi] <= chain_reg[gi-1];
                end
            end
        end
    endgenerate

    assign q = chain_reg[SYNC_STAGES-1];
endmodule

// File: rtl/gray_count_receiver.sv
// Gray count receiver: synchronizes a foreign-domain Gray count, decodes it,
// checks single-bit steps and tracks an extended up/down position.
// Define GRAY_RX_ERR_CNT_EN to add the saturating step-error counter.
module gray_count_receiver
    import gray_pkg::*;
#(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int POS_W       = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    gray_count_receiver_if.slave  bus
);
    // Never build a chain shorter than the safe minimum.
    localparam int STAGES = (SYNC_STAGES < SYNC_MIN) ? SYNC_MIN : SYNC_STAGES;

    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] s_bin;
    logic [5:0]       diff;

    gray_rx_state_t   state_reg, state_next;
    logic [WIDTH-1:0] prev_gray_reg, prev_gray_next;
    logic [WIDTH-1:0] hold_gray_reg, hold_gray_next;
    logic [WIDTH-1:0] bin_reg, bin_next;
    logic             valid_reg, valid_next;
    logic             up_reg, up_next;
    logic             dn_reg, dn_next;
    logic             err_reg, err_next;
    logic [POS_W-1:0] pos_reg, pos_next;

    gray_sync #(.WIDTH(WIDTH), .SYNC_STAGES(STAGES)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (bus.gray_in),
        .q   (s)
    );

    assign s_bin = WIDTH'(g2b(GRAY_MAX_W'(s)));
    assign diff  = popcount(GRAY_MAX_W'(s ^ prev_gray_reg));

    // State and output registers; every output is a flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            prev_gray_reg <= '0;
            hold_gray_reg <= '0;
            bin_reg       <= '0;
            valid_reg     <= 1'b0;
            up_reg        <= 1'b0;
            dn_reg        <= 1'b0;
            err_reg       <= 1'b0;
            pos_reg       <= '0;
        end else begin
            state_reg     <= state_next;
            prev_gray_reg <= prev_gray_next;
            hold_gray_reg <= hold_gray_next;
            bin_reg       <= bin_next;
            valid_reg     <= valid_next;
            up_reg        <= up_next;
            dn_reg        <= dn_next;
            err_reg       <= err_next;
            pos_reg       <= pos_next;
        end
    end

    // Next-state and output decisions, all taken from the synchronized sample.
    always_comb begin
        state_next     = state_reg;
        prev_gray_next = prev_gray_reg;
        hold_gray_next = hold_gray_reg;
        bin_next       = bin_reg;
        valid_next     = valid_reg;
        up_next        = 1'b0;
        dn_next        = 1'b0;
        err_next       = 1'b0;
        pos_next       = pos_reg;

        if (!bus.en) begin
            // Disabling always parks in IDLE; value and position are kept.
            state_next = IDLE;
            valid_next = 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    prev_gray_next = s;
                    bin_next       = s_bin;
                    valid_next     = 1'b1;
                    state_next     = TRACK;
                end
                TRACK: begin
                    if (diff == 6'd1) begin
                        prev_gray_next = s;
                        bin_next       = s_bin;
                        if (s_bin == bin_reg + WIDTH'(1)) begin
                            up_next  = 1'b1;
                            pos_next = pos_reg + POS_W'(1);
                        end else begin
                            dn_next  = 1'b1;
                            pos_next = pos_reg - POS_W'(1);
                        end
                    end else if (diff > 6'd1) begin
                        // Multi-bit jump: stop trusting the bus until it settles.
                        err_next       = 1'b1;
                        valid_next     = 1'b0;
                        hold_gray_next = s;
                        state_next     = HOLD;
                    end
                end
                HOLD: begin
                    if (s == hold_gray_reg) begin
                        prev_gray_next = s;
                        bin_next       = s_bin;
                        valid_next     = 1'b1;
                        state_next     = TRACK;
                    end else begin
                        hold_gray_next = s;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

`ifdef GRAY_RX_ERR_CNT_EN
    logic [7:0] err_cnt_reg;

    // Saturating count of step errors; cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                  err_cnt_reg <= 8'd0;
        else if (err_next && err_cnt_reg != 8'hFF) err_cnt_reg <= err_cnt_reg + 8'd1;
    end

    assign bus.err_cnt = err_cnt_reg;
`endif

    assign bus.bin_out   = bin_reg;
    assign bus.bin_valid = valid_reg;
    assign bus.step_up   = up_reg;
    assign bus.step_dn   = dn_reg;
    assign bus.step_err  = err_reg;
    assign bus.pos       = pos_reg;
endmodule
